// File: rtl/div_pkg.sv
// Shared types and helpers for the restoring divider and its BCD conversion stage.
package div_pkg;

    localparam int unsigned DIV_SIZE   = 4;
    localparam int unsigned BCD_DIGITS = 2;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    function automatic logic [3:0] add3_nibble(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // True when DIGITS decimal digits can hold every SIZE-bit unsigned value.
    function automatic bit bcd_fits(input int unsigned size, input int unsigned digits);
        longint unsigned pow10;
        longint unsigned max_bin;
        pow10   = 64'd1;
        max_bin = (64'd1 << size) - 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            pow10 = pow10 * 64'd10;
        end
        return pow10 > max_bin;
    endfunction

endpackage

// File: rtl/div_bcd_conv_dd_step.sv
// One double-dabble iteration: add-3 on every BCD nibble, then shift {bcd,bin} left by one.
module dd_step
    import div_pkg::*;
#(
    parameter int unsigned SIZE   = DIV_SIZE,
    parameter int unsigned DIGITS = BCD_DIGITS
) (
    input  logic [4*DIGITS-1:0] bcd,
    input  logic [SIZE-1:0]     bin,
    output logic [4*DIGITS-1:0] bcd_next,
    output logic [SIZE-1:0]     bin_next
);

    logic [4*DIGITS-1:0] bcd_adj;

    always_comb begin
        bcd_adj = '0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            bcd_adj[4*d +: 4] = add3_nibble(bcd[4*d +: 4]);
        end
    end

    assign bcd_next = {bcd_adj[4*DIGITS-2:0], bin[SIZE-1]};
    assign bin_next = {bin[SIZE-2:0], 1'b0};

endmodule

// File: rtl/div_bcd_conv.sv
// Sequential binary-to-BCD converter for the divider's quotient/remainder pair,
// one bit per clock, with valid/ready handshakes on both sides.
module div_bcd_conv
    import div_pkg::*;
#(
    parameter int unsigned SIZE   = DIV_SIZE,
    parameter int unsigned DIGITS = BCD_DIGITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE-1:0]     i_shang,
    input  logic [SIZE-1:0]     i_yushu,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] o_shang_bcd,
    output logic [4*DIGITS-1:0] o_yushu_bcd
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(SIZE) + 1;

    if (!bcd_fits(SIZE, DIGITS)) begin : g_digits_check
        $error("div_bcd_conv: DIGITS too small to represent 2^SIZE-1");
    end

    state_t          state;
    logic [CW-1:0]   counter;
    logic [SIZE-1:0] bin_s, bin_y, bin_s_nx, bin_y_nx;
    logic [BW-1:0]   bcd_s, bcd_y, bcd_s_nx, bcd_y_nx;

    dd_step #(.SIZE(SIZE), .DIGITS(DIGITS)) u_step_shang (
        .bcd      (bcd_s),
        .bin      (bin_s),
        .bcd_next (bcd_s_nx),
        .bin_next (bin_s_nx)
    );

    dd_step #(.SIZE(SIZE), .DIGITS(DIGITS)) u_step_yushu (
        .bcd      (bcd_y),
        .bin      (bin_y),
        .bcd_next (bcd_y_nx),
        .bin_next (bin_y_nx)
    );

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            counter     <= '0;
            bin_s       <= '0;
            bin_y       <= '0;
            bcd_s       <= '0;
            bcd_y       <= '0;
            o_shang_bcd <= '0;
            o_yushu_bcd <= '0;
            out_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_s   <= i_shang;
                        bin_y   <= i_yushu;
                        bcd_s   <= '0;
                        bcd_y   <= '0;
                        counter <= '0;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    bin_s   <= bin_s_nx;
                    bin_y   <= bin_y_nx;
                    bcd_s   <= bcd_s_nx;
                    bcd_y   <= bcd_y_nx;
                    counter <= counter + CW'(1);
                    // The final iteration's result goes straight to the output registers.
                    if (counter == CW'(SIZE - 1)) begin
                        o_shang_bcd <= bcd_s_nx;
                        o_yushu_bcd <= bcd_y_nx;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
